// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: one command yields one frame of incrementing
// payload beats carrying tid/tdest, with tlast on the final beat and run statistics.
module axis_frame_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_seed,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [DEST_WIDTH-1:0] cmd_dest,
    input  logic                  cmd_err,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic [31:0]           frame_count,
    output logic [15:0]           drop_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic [DATA_WIDTH-1:0]   tdata_r, tdata_s;
    logic [LEN_WIDTH-1:0]    remaining_r, remaining_s;
    logic                    tvalid_r, tvalid_s;
    logic                    tlast_r, tlast_s;
    logic                    tuser_r, tuser_s;
    logic                    err_r, err_s;
    logic [ID_WIDTH-1:0]     tid_r, tid_s;
    logic [DEST_WIDTH-1:0]   tdest_r, tdest_s;
    logic                    busy_r, busy_s;
    logic                    cmd_ready_r, cmd_ready_s;
    logic [31:0]             frame_count_r, frame_count_s;
    logic [15:0]             drop_count_r, drop_count_s;

    // Next-state and next-output computation; tlast/tuser are precomputed so
    // every output comes straight from a flop.
    always_comb begin
        state_s       = state_r;
        tdata_s       = tdata_r;
        remaining_s   = remaining_r;
        tvalid_s      = tvalid_r;
        tlast_s       = tlast_r;
        tuser_s       = tuser_r;
        err_s         = err_r;
        tid_s         = tid_r;
        tdest_s       = tdest_r;
        busy_s        = busy_r;
        cmd_ready_s   = cmd_ready_r;
        frame_count_s = frame_count_r;
        drop_count_s  = drop_count_r;
        case (state_r)
            IDLE: begin
                cmd_ready_s = 1'b1;
                if (cmd_valid && cmd_ready_r) begin
                    if (cmd_len == {LEN_WIDTH{1'b0}}) begin
                        if (drop_count_r != 16'hFFFF) begin
                            drop_count_s = drop_count_r + 16'd1;
                        end else begin
                            drop_count_s = drop_count_r;
                        end
                    end else begin
                        state_s     = SEND;
                        tdata_s     = cmd_seed;
                        remaining_s = cmd_len;
                        err_s       = cmd_err;
                        tid_s       = cmd_id;
                        tdest_s     = cmd_dest;
                        tvalid_s    = 1'b1;
                        busy_s      = 1'b1;
                        cmd_ready_s = 1'b0;
                        tlast_s     = (cmd_len == LEN_WIDTH'(1));
                        tuser_s     = cmd_err && (cmd_len == LEN_WIDTH'(1));
                    end
                end else begin
                    drop_count_s = drop_count_r;
                end
            end
            SEND: begin
                if (tvalid_r && m_axis_tready) begin
                    tdata_s     = tdata_r + DATA_WIDTH'(1);
                    remaining_s = remaining_r - LEN_WIDTH'(1);
                    if (tlast_r) begin
                        state_s       = IDLE;
                        tvalid_s      = 1'b0;
                        busy_s        = 1'b0;
                        tlast_s       = 1'b0;
                        tuser_s       = 1'b0;
                        cmd_ready_s   = 1'b1;
                        frame_count_s = frame_count_r + 32'd1;
                    end else begin
                        tlast_s = (remaining_r == LEN_WIDTH'(2));
                        tuser_s = err_r && (remaining_r == LEN_WIDTH'(2));
                    end
                end else begin
                    tdata_s = tdata_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, stream outputs and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tdata_r       <= {DATA_WIDTH{1'b0}};
            remaining_r   <= {LEN_WIDTH{1'b0}};
            tvalid_r      <= 1'b0;
            tlast_r       <= 1'b0;
            tuser_r       <= 1'b0;
            err_r         <= 1'b0;
            tid_r         <= {ID_WIDTH{1'b0}};
            tdest_r       <= {DEST_WIDTH{1'b0}};
            busy_r        <= 1'b0;
            cmd_ready_r   <= 1'b0;
            frame_count_r <= 32'd0;
            drop_count_r  <= 16'd0;
        end else begin
            tdata_r       <= tdata_s;
            remaining_r   <= remaining_s;
            tvalid_r      <= tvalid_s;
            tlast_r       <= tlast_s;
            tuser_r       <= tuser_s;
            err_r         <= err_s;
            tid_r         <= tid_s;
            tdest_r       <= tdest_s;
            busy_r        <= busy_s;
            cmd_ready_r   <= cmd_ready_s;
            frame_count_r <= frame_count_s;
            drop_count_r  <= drop_count_s;
        end
    end

    assign cmd_ready     = cmd_ready_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tkeep  = tvalid_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tid    = tid_r;
    assign m_axis_tdest  = tdest_r;
    assign m_axis_tuser  = tuser_r;
    assign busy          = busy_r;
    assign frame_count   = frame_count_r;
    assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed self-checking bench for axis_frame_gen: inputs change and outputs
// are sampled on the falling edge, one clock apart.
module tb_axis_frame_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic [31:0] cmd_seed;
    logic [7:0]  cmd_id;
    logic [7:0]  cmd_dest;
    logic        cmd_err;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tid;
    logic [7:0]  m_axis_tdest;
    logic        m_axis_tuser;
    logic        busy;
    logic [31:0] frame_count;
    logic [15:0] drop_count;

    int n_cmp = 0;
    int n_err = 0;

    axis_frame_gen dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_seed(cmd_seed), .cmd_id(cmd_id), .cmd_dest(cmd_dest), .cmd_err(cmd_err),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
        .busy(busy), .frame_count(frame_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d, input logic l,
                            input logic u, input logic [7:0] id, input logic [7:0] dst);
        chk({tag, ".tvalid"}, 64'(m_axis_tvalid), 64'd1);
        chk({tag, ".tkeep"},  64'(m_axis_tkeep),  64'd1);
        chk({tag, ".tdata"},  64'(m_axis_tdata),  64'(d));
        chk({tag, ".tlast"},  64'(m_axis_tlast),  64'(l));
        chk({tag, ".tuser"},  64'(m_axis_tuser),  64'(u));
        chk({tag, ".tid"},    64'(m_axis_tid),    64'(id));
        chk({tag, ".tdest"},  64'(m_axis_tdest),  64'(dst));
        chk({tag, ".busy"},   64'(busy),          64'd1);
        chk({tag, ".cmd_ready"}, 64'(cmd_ready),  64'd0);
    endtask

    task automatic send_cmd(input logic [15:0] len, input logic [31:0] seed,
                            input logic [7:0] id, input logic [7:0] dst, input logic err);
        cmd_valid = 1'b1; cmd_len = len; cmd_seed = seed;
        cmd_id = id; cmd_dest = dst; cmd_err = err;
        tick();
        cmd_valid = 1'b0;
    endtask

    logic        bp_rdy  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] bp_data [6] = '{32'h20, 32'h21, 32'h21, 32'h21, 32'h22, 32'h22};
    logic        bp_last [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_len = 16'd0; cmd_seed = 32'd0;
        cmd_id = 8'd0; cmd_dest = 8'd0; cmd_err = 1'b0; m_axis_tready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        chk("rst.cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst.tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst.tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst.tuser", 64'(m_axis_tuser), 64'd0);
        chk("rst.tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst.tid", 64'(m_axis_tid), 64'd0);
        chk("rst.tdest", 64'(m_axis_tdest), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.frame_count", 64'(frame_count), 64'd0);
        chk("rst.drop_count", 64'(drop_count), 64'd0);
        rst = 1'b0;
        chk("rel.cmd_ready_low", 64'(cmd_ready), 64'd0);
        tick();
        chk("rel.cmd_ready_high", 64'(cmd_ready), 64'd1);

        // Basic frame
        send_cmd(16'd4, 32'h10, 8'd3, 8'd5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_beat("basic", 32'h10 + 32'(i), (i == 3), 1'b0, 8'd3, 8'd5);
            tick();
        end
        chk("basic.tvalid_end", 64'(m_axis_tvalid), 64'd0);
        chk("basic.busy_end", 64'(busy), 64'd0);
        chk("basic.cmd_ready_end", 64'(cmd_ready), 64'd1);
        chk("basic.frame_count", 64'(frame_count), 64'd1);
        chk("basic.tid_held", 64'(m_axis_tid), 64'd3);
        chk("basic.tdest_held", 64'(m_axis_tdest), 64'd5);

        // Backpressure
        m_axis_tready = 1'b0;
        send_cmd(16'd3, 32'h20, 8'd1, 8'd2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            m_axis_tready = bp_rdy[i];
            chk_beat("bp", bp_data[i], bp_last[i], 1'b0, 8'd1, 8'd2);
            tick();
        end
        m_axis_tready = 1'b1;
        chk("bp.tvalid_end", 64'(m_axis_tvalid), 64'd0);
        chk("bp.frame_count", 64'(frame_count), 64'd2);

        // Wrap and error flag
        send_cmd(16'd3, 32'hFFFF_FFFE, 8'd6, 8'd7, 1'b1);
        chk_beat("wrap0", 32'hFFFF_FFFE, 1'b0, 1'b0, 8'd6, 8'd7);
        tick();
        chk_beat("wrap1", 32'hFFFF_FFFF, 1'b0, 1'b0, 8'd6, 8'd7);
        tick();
        chk_beat("wrap2", 32'h0000_0000, 1'b1, 1'b1, 8'd6, 8'd7);
        tick();
        chk("wrap.tvalid_end", 64'(m_axis_tvalid), 64'd0);
        chk("wrap.tuser_end", 64'(m_axis_tuser), 64'd0);
        chk("wrap.frame_count", 64'(frame_count), 64'd3);

        // Single beat, then an illegal zero-length command
        send_cmd(16'd1, 32'h55, 8'd2, 8'd3, 1'b0);
        chk_beat("single", 32'h55, 1'b1, 1'b0, 8'd2, 8'd3);
        tick();
        chk("single.tvalid_end", 64'(m_axis_tvalid), 64'd0);
        chk("single.frame_count", 64'(frame_count), 64'd4);
        send_cmd(16'd0, 32'h77, 8'd9, 8'd9, 1'b0);
        chk("zero.tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("zero.busy", 64'(busy), 64'd0);
        chk("zero.cmd_ready", 64'(cmd_ready), 64'd1);
        chk("zero.drop_count", 64'(drop_count), 64'd1);
        chk("zero.frame_count", 64'(frame_count), 64'd4);
        chk("zero.tid_held", 64'(m_axis_tid), 64'd2);

        // Reset in the middle of a frame
        send_cmd(16'd8, 32'h100, 8'd1, 8'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_beat("mid", 32'h100 + 32'(i), 1'b0, 1'b0, 8'd1, 8'd1);
            tick();
        end
        rst = 1'b1;
        tick();
        chk("mid.tvalid_rst", 64'(m_axis_tvalid), 64'd0);
        chk("mid.tlast_rst", 64'(m_axis_tlast), 64'd0);
        chk("mid.frame_count", 64'(frame_count), 64'd0);
        chk("mid.drop_count", 64'(drop_count), 64'd0);
        rst = 1'b0;
        tick();
        chk("mid.cmd_ready", 64'(cmd_ready), 64'd1);
        send_cmd(16'd2, 32'h200, 8'd7, 8'd9, 1'b0);
        chk_beat("post0", 32'h200, 1'b0, 1'b0, 8'd7, 8'd9);
        tick();
        chk_beat("post1", 32'h201, 1'b1, 1'b0, 8'd7, 8'd9);
        tick();
        chk("post.frame_count", 64'(frame_count), 64'd1);

        // Back-to-back: second command waits while the first frame is sent
        cmd_valid = 1'b1; cmd_len = 16'd2; cmd_seed = 32'h300;
        cmd_id = 8'd4; cmd_dest = 8'd6; cmd_err = 1'b0;
        tick();
        cmd_seed = 32'h400; cmd_id = 8'd8; cmd_dest = 8'd10;
        chk_beat("b2b.a0", 32'h300, 1'b0, 1'b0, 8'd4, 8'd6);
        tick();
        chk_beat("b2b.a1", 32'h301, 1'b1, 1'b0, 8'd4, 8'd6);
        tick();
        chk("b2b.gap_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("b2b.gap_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("b2b.gap_tid", 64'(m_axis_tid), 64'd4);
        tick();
        cmd_valid = 1'b0;
        chk_beat("b2b.b0", 32'h400, 1'b0, 1'b0, 8'd8, 8'd10);
        tick();
        chk_beat("b2b.b1", 32'h401, 1'b1, 1'b0, 8'd8, 8'd10);
        tick();
        chk("b2b.tvalid_end", 64'(m_axis_tvalid), 64'd0);
        chk("b2b.frame_count", 64'(frame_count), 64'd3);
        tick();
        chk("b2b.no_extra", 64'(m_axis_tvalid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
